// File: rtl/spgd_update.sv
// Two-sided SPGD iteration engine: applies u+delta, then u-delta, captures the metric
// for each phase after a settle window, and steps u along the measured gradient.
module spgd_update #(
    parameter int OUT_WIDTH     = 14,
    parameter int CTRL_WIDTH    = 16,
    parameter int METRIC_WIDTH  = 16,
    parameter int GAIN_SHIFT    = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [OUT_WIDTH-1:0]  delta_0,
    input  logic signed [OUT_WIDTH-1:0]  delta_1,
    input  logic [METRIC_WIDTH-1:0]      metric,
    input  logic                         metric_valid,
    output logic signed [CTRL_WIDTH-1:0] ctrl_0,
    output logic signed [CTRL_WIDTH-1:0] ctrl_1,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  iter_count
);

    localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int DJ_W   = METRIC_WIDTH + 1;
    localparam int P_W    = METRIC_WIDTH + 1 + OUT_WIDTH;
    localparam int WIDE_W = P_W + CTRL_WIDTH + 1;

    localparam logic signed [WIDE_W-1:0] SAT_MAX =
        {{(WIDE_W-CTRL_WIDTH+1){1'b0}}, {(CTRL_WIDTH-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] SAT_MIN =
        {{(WIDE_W-CTRL_WIDTH+1){1'b1}}, {(CTRL_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PLUS, WAIT_P, MINUS, WAIT_M, UPDATE} state_t;

    state_t state, state_nxt;

    logic signed [CTRL_WIDTH-1:0] u_0, u_1;
    logic signed [OUT_WIDTH-1:0]  d_0, d_1;
    logic [METRIC_WIDTH-1:0]      j_plus, j_minus;
    logic [CNT_W-1:0]             settle_cnt;
    logic                         metric_take;

    logic signed [DJ_W-1:0]       dj;
    logic signed [P_W-1:0]        p_0, p_1, g_0, g_1;
    logic signed [CTRL_WIDTH-1:0] plus_0, plus_1, minus_0, minus_1, u_new_0, u_new_1;

    // Inputs are widened far enough that no sum can wrap before clamping.
    function automatic logic signed [CTRL_WIDTH-1:0] sat(input logic signed [WIDE_W-1:0] x);
        if (x > SAT_MAX)
            return SAT_MAX[CTRL_WIDTH-1:0];
        else if (x < SAT_MIN)
            return SAT_MIN[CTRL_WIDTH-1:0];
        else
            return x[CTRL_WIDTH-1:0];
    endfunction

    assign metric_take = metric_valid && (settle_cnt == '0);
    assign busy        = (state != IDLE);

    always_comb begin
        dj      = {1'b0, j_plus} - {1'b0, j_minus};
        p_0     = P_W'(dj) * P_W'(d_0);
        p_1     = P_W'(dj) * P_W'(d_1);
        g_0     = p_0 >>> GAIN_SHIFT;
        g_1     = p_1 >>> GAIN_SHIFT;
        u_new_0 = sat(WIDE_W'(u_0) + WIDE_W'(g_0));
        u_new_1 = sat(WIDE_W'(u_1) + WIDE_W'(g_1));
        plus_0  = sat(WIDE_W'(u_0) + WIDE_W'(delta_0));
        plus_1  = sat(WIDE_W'(u_1) + WIDE_W'(delta_1));
        minus_0 = sat(WIDE_W'(u_0) - WIDE_W'(d_0));
        minus_1 = sat(WIDE_W'(u_1) - WIDE_W'(d_1));
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PLUS;
            PLUS:    state_nxt = WAIT_P;
            WAIT_P:  if (metric_take) state_nxt = MINUS;
            MINUS:   state_nxt = WAIT_M;
            WAIT_M:  if (metric_take) state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The settle counter is reloaded on the edge that changes ctrl, so it reaches
    // zero exactly SETTLE_CYCLES cycles after the new control word appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            u_0        <= '0;
            u_1        <= '0;
            ctrl_0     <= '0;
            ctrl_1     <= '0;
            d_0        <= '0;
            d_1        <= '0;
            j_plus     <= '0;
            j_minus    <= '0;
            settle_cnt <= '0;
            done       <= 1'b0;
            iter_count <= '0;
        end else begin
            done <= 1'b0;
            if (settle_cnt != '0)
                settle_cnt <= settle_cnt - 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        d_0        <= delta_0;
                        d_1        <= delta_1;
                        ctrl_0     <= plus_0;
                        ctrl_1     <= plus_1;
                        settle_cnt <= CNT_W'(SETTLE_CYCLES);
                    end
                end
                WAIT_P: begin
                    if (metric_take) begin
                        j_plus     <= metric;
                        ctrl_0     <= minus_0;
                        ctrl_1     <= minus_1;
                        settle_cnt <= CNT_W'(SETTLE_CYCLES);
                    end
                end
                WAIT_M: begin
                    if (metric_take)
                        j_minus <= metric;
                end
                UPDATE: begin
                    u_0        <= u_new_0;
                    u_1        <= u_new_1;
                    ctrl_0     <= u_new_0;
                    ctrl_1     <= u_new_1;
                    done       <= 1'b1;
                    iter_count <= iter_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/spgd_update.md
Name: spgd_update

Overview:
- Consumer of the dual-channel perturbation generator. Runs one two-sided SPGD iteration per start pulse.
- Per iteration: latches the two signed perturbations, drives control = u+δ, then u−δ, to the actuators. Captures the metric for each phase.
- Update rule: u_i ← u_i + ((J+ − J−)·δ_i) >>> GAIN_SHIFT, with saturation.
- Sits between the RNG pair, the actuator DACs and the metric ADC front end.

Parameters:
OUT_WIDTH, 14, perturbation width (signed two's complement), matches RNG output width
CTRL_WIDTH, 16, signed control word width
METRIC_WIDTH, 16, unsigned metric width
GAIN_SHIFT, 8, arithmetic right shift applied to the gradient product
SETTLE_CYCLES, 4, cycles after each control change during which metric_valid is ignored (≥1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin iteration; sampled only in IDLE
delta_0  in  OUT_WIDTH  channel-0 perturbation (signed)
delta_1  in  OUT_WIDTH  channel-1 perturbation (signed)
metric  in  METRIC_WIDTH  measured metric (unsigned)
metric_valid  in  1  metric qualifier
ctrl_0  out  CTRL_WIDTH  channel-0 actuator word (signed, registered)
ctrl_1  out  CTRL_WIDTH  channel-1 actuator word (signed, registered)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the update is applied
iter_count  out  16  completed iterations, wraps 65535→0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, and has priority over all other activity.
- Reset values: u_0 = u_1 = 0; ctrl_0 = ctrl_1 = 0; busy = 0; done = 0; iter_count = 0; state = IDLE.
- Reset mid-iteration aborts the iteration and discards the latched δ and J values.
- FSM states: IDLE → PLUS → WAIT_P → MINUS → WAIT_M → UPDATE → IDLE.
- IDLE:
  - ctrl_i = u_i.
  - If start=1 in cycle T, latch delta_0 and delta_1 and go to PLUS.
  - start while busy is ignored (no queueing).
- PLUS (T+1):
  - ctrl_i = sat(u_i + δ_i), held until MINUS.
  - Settle counter loads SETTLE_CYCLES; go to WAIT_P.
- Settle window: metric_valid is ignored in cycles T+1 .. T+SETTLE_CYCLES.
- WAIT_P:
  - The first metric_valid at or after cycle T+1+SETTLE_CYCLES latches J+ and moves to MINUS.
  - There is no timeout; the block waits indefinitely.
- MINUS:
  - The cycle after J+ is accepted, ctrl_i = sat(u_i − δ_i).
  - Same settle rule applies. In WAIT_M the first qualifying metric_valid latches J− and moves to UPDATE.
- UPDATE: ctrl_i holds u−δ.
  - dJ = J+ − J−, signed, METRIC_WIDTH+1 bits.
  - p_i = dJ·δ_i, signed, METRIC_WIDTH+1+OUT_WIDTH bits.
  - g_i = p_i >>> GAIN_SHIFT (arithmetic shift, floor rounding).
  - u_i_new = sat(u_i + g_i).
- Cycle after UPDATE:
  - u_i and ctrl_i take u_i_new.
  - done = 1 for this single cycle; busy = 0; iter_count increments; state = IDLE.
  - start in this cycle is accepted (back-to-back iterations allowed).
- Latency: if J− is accepted at cycle M, done is asserted at M+2.
- Saturation: sat() clamps to [−2^(CTRL_WIDTH−1), 2^(CTRL_WIDTH−1)−1] and is applied independently per channel. All sums are computed in a width that cannot overflow before clamping.
- metric_valid while in IDLE, PLUS, MINUS or UPDATE is ignored.
- The delta inputs are only sampled on an accepted start; they may change freely at all other times.

Test Plan:
- Reset then idle:
  - Stimulus: rst for 2 cycles, then no start.
  - Required: ctrl_0 = ctrl_1 = 0, busy = 0, done = 0, iter_count = 0.
- Basic iteration, defaults:
  - Stimulus: delta_0 = 100, delta_1 = −50; metric 300 in the plus phase, 200 in the minus phase.
  - Required: ctrl = (100, −50) during plus and (−100, 50) during minus.
  - Required after done: ctrl_0 = 39, ctrl_1 = −20 (floor of −19.53); iter_count = 1.
- Settle enforcement:
  - Stimulus: metric_valid held high continuously from the start cycle T.
  - Required: J+ is taken exactly at T+5; MINUS ctrl appears at T+6; J− is taken at T+10; done at T+12.
- Saturation:
  - Stimulus: delta_0 = 8191, J+ = 65535, J− = 0.
  - Required: ctrl_0 = 32767 after done.
  - Stimulus, next iteration: same delta_0.
  - Required: plus phase ctrl_0 = 32767 (clamped); minus phase ctrl_0 = 24576.
  - Mirror case: delta_0 = −8192 drives ctrl_0 to −32768.
- Start while busy and reset mid-op:
  - Stimulus: start pulses during WAIT_P.
  - Required: ignored, with exactly one done per accepted start.
  - Stimulus: rst asserted in WAIT_M.
  - Required: next cycle ctrl = 0, busy = 0, iter_count = 0, and no done pulse.
- Back-to-back iterations and wrap:
  - Stimulus: start asserted in each done cycle.
  - Required: busy deasserts for only that one cycle per iteration.
  - Stimulus: force 65536 iterations.
  - Required: iter_count wraps to 0.
